// File: rtl/trg_ack_sequencer.sv
// One SCROD trigger cycle: accept request, pulse TRG to enabled lanes, collect acks
// with timeout, hold off, rearm. Per-lane sync/accumulate logic lives in trg_ack_lane.

module trg_ack_lane (
   input  logic clk,
   input  logic rst_n,
   input  logic ack,
   input  logic mask_in,
   input  logic accept,
   input  logic fire_end,
   input  logic acc_en,
   input  logic done_ok,
   input  logic done_abort,
   output logic trg,
   output logic missing,
   output logic lane_ok
);
   logic ack_m, ack_s, mask_l, acc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ack_m   <= 1'b0;
         ack_s   <= 1'b0;
         mask_l  <= 1'b0;
         acc     <= 1'b0;
         trg     <= 1'b0;
         missing <= 1'b0;
      end else begin
         ack_m <= ack;
         ack_s <= ack_m;
         if (accept) begin
            mask_l <= mask_in;
            acc    <= 1'b0;
            trg    <= mask_in;
         end else begin
            if (acc_en)   acc <= acc | (ack_s & mask_l);
            if (fire_end) trg <= 1'b0;
         end
         if (done_ok)         missing <= 1'b0;
         else if (done_abort) missing <= mask_l & ~acc;
      end
   end

   // a disabled lane is always satisfied; an enabled one needs a past or current ack
   assign lane_ok = ~mask_l | acc | ack_s;
endmodule

module trg_ack_sequencer #(
   parameter int N_SCROD     = 12,
   parameter int TRG_WIDTH   = 4,
   parameter int ACK_TIMEOUT = 1023,
   parameter int HOLDOFF     = 16,
   parameter int CNT_W       = 16
) (
   input  logic               CLK_80MHZ,
   input  logic               RESET_N,
   input  logic               TRG_REQ,
   input  logic               TRG_SOFT,
   input  logic [N_SCROD-1:0] TRG_MASK,
   input  logic [N_SCROD-1:0] ACK,
   output logic [N_SCROD-1:0] TRG,
   output logic               BUSY,
   output logic [CNT_W-1:0]   TRG_COUNT,
   output logic [CNT_W-1:0]   LOST_COUNT,
   output logic [CNT_W-1:0]   TIMEOUT_COUNT,
   output logic [N_SCROD-1:0] MISSING_ACK
);
   localparam int TMR_W  = $clog2(ACK_TIMEOUT + 1);
   localparam int HLD_W  = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
   localparam int FIRE_W = $clog2(TRG_WIDTH + 1);
   localparam logic [TMR_W-1:0]  TMR_LAST  = TMR_W'(ACK_TIMEOUT - 1);
   localparam logic [HLD_W-1:0]  HLD_LAST  = HLD_W'((HOLDOFF > 0) ? HOLDOFF - 1 : 0);
   localparam logic [FIRE_W-1:0] FIRE_LAST = FIRE_W'(TRG_WIDTH - 1);

   typedef enum logic [1:0] {IDLE, FIRE, WAIT_ACK, HOLD} state_t;
   localparam state_t AFTER_ACK = (HOLDOFF == 0) ? IDLE : HOLD;

   state_t state, state_nx;
   logic   req_q, soft_q, arm, req;
   logic   accept, drop, fire_end, done_ok, done_abort, acc_en;
   logic [N_SCROD-1:0] lane_ok;
   logic [FIRE_W-1:0]  fire_cnt;
   logic [TMR_W-1:0]   timer;
   logic [HLD_W-1:0]   hold_cnt;

   // arm keeps a level already high at reset release from reading as a rising edge
   assign req    = arm & ((TRG_REQ & ~req_q) | (TRG_SOFT & ~soft_q));
   assign BUSY   = (state != IDLE);
   assign acc_en = (state == FIRE) || (state == WAIT_ACK);

   for (genvar i = 0; i < N_SCROD; i++) begin : g_lane
      trg_ack_lane u_lane (
         .clk       (CLK_80MHZ),
         .rst_n     (RESET_N),
         .ack       (ACK[i]),
         .mask_in   (TRG_MASK[i]),
         .accept    (accept),
         .fire_end  (fire_end),
         .acc_en    (acc_en),
         .done_ok   (done_ok),
         .done_abort(done_abort),
         .trg       (TRG[i]),
         .missing   (MISSING_ACK[i]),
         .lane_ok   (lane_ok[i])
      );
   end

   always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
      if (!RESET_N) state <= IDLE;
      else          state <= state_nx;
   end

   always_comb begin
      state_nx   = state;
      accept     = 1'b0;
      drop       = 1'b0;
      fire_end   = 1'b0;
      done_ok    = 1'b0;
      done_abort = 1'b0;
      case (state)
         IDLE: begin
            if (req) begin
               if (|TRG_MASK) begin
                  accept   = 1'b1;
                  state_nx = FIRE;
               end else begin
                  drop = 1'b1;
               end
            end
         end
         FIRE: begin
            drop = req;
            if (fire_cnt == FIRE_LAST) begin
               fire_end = 1'b1;
               state_nx = WAIT_ACK;
            end
         end
         WAIT_ACK: begin
            drop = req;
            // completion takes priority over a timeout landing on the same clock
            if (&lane_ok) begin
               done_ok  = 1'b1;
               state_nx = AFTER_ACK;
            end else if (timer == TMR_LAST) begin
               done_abort = 1'b1;
               state_nx   = AFTER_ACK;
            end
         end
         HOLD: begin
            drop = req;
            if (hold_cnt == HLD_LAST) state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge CLK_80MHZ or negedge RESET_N) begin
      if (!RESET_N) begin
         req_q         <= 1'b0;
         soft_q        <= 1'b0;
         arm           <= 1'b0;
         fire_cnt      <= '0;
         timer         <= '0;
         hold_cnt      <= '0;
         TRG_COUNT     <= '0;
         LOST_COUNT    <= '0;
         TIMEOUT_COUNT <= '0;
      end else begin
         req_q  <= TRG_REQ;
         soft_q <= TRG_SOFT;
         arm    <= 1'b1;

         if (accept)                fire_cnt <= '0;
         else if (state == FIRE)    fire_cnt <= fire_cnt + FIRE_W'(1);

         if (fire_end)              timer <= '0;
         else if (state == WAIT_ACK) timer <= timer + TMR_W'(1);

         if (done_ok || done_abort) hold_cnt <= '0;
         else if (state == HOLD)    hold_cnt <= hold_cnt + HLD_W'(1);

         // statistics saturate at all-ones
         if (accept && !(&TRG_COUNT))         TRG_COUNT     <= TRG_COUNT + CNT_W'(1);
         if (drop && !(&LOST_COUNT))          LOST_COUNT    <= LOST_COUNT + CNT_W'(1);
         if (done_abort && !(&TIMEOUT_COUNT)) TIMEOUT_COUNT <= TIMEOUT_COUNT + CNT_W'(1);
      end
   end
endmodule

// File: tb/tb_trg_ack_sequencer.sv
// Bench for trg_ack_sequencer: directed scenarios plus randomized requests against
// a cycle-count model of the trigger/ack/deadtime rules.

module tb_trg_ack_sequencer;
   localparam int N  = 12;
   localparam int W  = 4;
   localparam int T  = 1023;
   localparam int H  = 16;
   localparam int CW = 4;   // narrow counters so saturation is reachable
   localparam int CMAX = (1 << CW) - 1;

   logic clk = 1'b0;
   logic rst_n, trg_req, trg_soft;
   logic [N-1:0]  trg_mask, ack, trg, missing;
   logic          busy;
   logic [CW-1:0] trg_cnt, lost_cnt, to_cnt;

   int n_chk = 0, n_fail = 0;
   int e_trg, e_lost, e_to, n;

   // reference model state
   bit mdl_on = 1'b0, m_first, m_pr, m_ps, m_rq;
   int m_busy, m_fire, m_trgc, m_lost, m_to;
   logic [N-1:0] m_maskl, m_miss;

   always #5 clk = ~clk;

   trg_ack_sequencer #(.N_SCROD(N), .TRG_WIDTH(W), .ACK_TIMEOUT(T), .HOLDOFF(H), .CNT_W(CW)) dut (
      .CLK_80MHZ(clk), .RESET_N(rst_n), .TRG_REQ(trg_req), .TRG_SOFT(trg_soft),
      .TRG_MASK(trg_mask), .ACK(ack), .TRG(trg), .BUSY(busy),
      .TRG_COUNT(trg_cnt), .LOST_COUNT(lost_cnt), .TIMEOUT_COUNT(to_cnt), .MISSING_ACK(missing)
   );

   function automatic int sat(input int v);
      return (v >= CMAX) ? v : v + 1;
   endfunction

   // Model: a cycle is W pulse clocks, then either 1 ack clock or T timeout clocks, then H.
   // Acks are held static around each acceptance, so the outcome is known at acceptance.
   always @(posedge clk) if (mdl_on) begin
      m_rq = !m_first && ((trg_req && !m_pr) || (trg_soft && !m_ps));
      m_first = 1'b0;
      m_pr = trg_req;
      m_ps = trg_soft;
      if (m_busy > 0) begin
         if (m_rq) m_lost = sat(m_lost);
         m_busy--;
         if (m_fire > 0) m_fire--;
      end else if (m_rq) begin
         if (trg_mask == '0) m_lost = sat(m_lost);
         else begin
            m_maskl = trg_mask;
            m_trgc  = sat(m_trgc);
            m_fire  = W;
            if ((ack & trg_mask) == trg_mask) begin
               m_busy = W + 1 + H;
               m_miss = '0;
            end else begin
               m_busy = W + T + H;
               m_miss = trg_mask & ~ack;
               m_to   = sat(m_to);
            end
         end
      end
   end

   task automatic step();
      @(negedge clk);
   endtask

   task automatic wait_idle(input string tag, input int cap);
      int k = 0;
      while (busy === 1'b1 && k < cap) begin step(); k++; end
      n_chk++;
      if (busy !== 1'b0) begin n_fail++; $display("FAIL %s_idle_timeout: busy=%b after %0d clks", tag, busy, k); end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; trg_req = 1'b1; trg_soft = 1'b0; trg_mask = 12'hFFF; ack = '0;
      step(); step();
      n_chk++;
      if ({trg, busy, trg_cnt, lost_cnt, to_cnt, missing} !== '0) begin
         n_fail++; $display("FAIL reset_state: trg=%h busy=%b cnt=%0d/%0d/%0d miss=%h want all 0",
                            trg, busy, trg_cnt, lost_cnt, to_cnt, missing);
      end
      rst_n = 1'b1;
      for (int i = 0; i < 8; i++) begin
         step();
         n_chk++;
         if ({trg, busy} !== '0) begin n_fail++; $display("FAIL reset_release_held: trg=%h busy=%b want 0/0", trg, busy); end
      end
      n_chk++;
      if ({trg_cnt, lost_cnt} !== '0) begin n_fail++; $display("FAIL reset_no_req: trg_cnt=%0d lost=%0d want 0/0", trg_cnt, lost_cnt); end
      trg_req = 1'b0;
      step();
      e_trg = 0; e_lost = 0; e_to = 0;
   endtask

   task automatic test_nominal();
      trg_mask = 12'h00F; ack = '0; trg_soft = 1'b1;
      step();
      e_trg = sat(e_trg);
      for (int i = 0; i < W; i++) begin
         n_chk++;
         if ({trg, busy} !== {12'h00F, 1'b1}) begin n_fail++; $display("FAIL nom_pulse%0d: trg=%h busy=%b want 00f/1", i, trg, busy); end
         step();
      end
      n_chk++;
      if (trg !== '0) begin n_fail++; $display("FAIL nom_trg_fall: trg=%h want 000", trg); end
      step(); step(); step();
      ack = 12'h00F;
      n = 0;
      while (busy === 1'b1 && n < 100) begin step(); n++; end
      // 2 synchronizer clocks, 1 completion clock, then the deadtime
      n_chk++;
      if (n !== 3 + H) begin n_fail++; $display("FAIL nom_busy_len: %0d clks after ack want %0d", n, 3 + H); end
      n_chk++;
      if ({trg_cnt, to_cnt, missing} !== {CW'(e_trg), CW'(e_to), 12'h000}) begin
         n_fail++; $display("FAIL nom_stats: trg_cnt=%0d to=%0d miss=%h want %0d/%0d/000", trg_cnt, to_cnt, missing, e_trg, e_to);
      end
      ack = '0; trg_soft = 1'b0;
      step();
   endtask

   task automatic test_timeout();
      trg_mask = 12'h00F; trg_req = 1'b1;
      step();
      e_trg = sat(e_trg); e_to = sat(e_to);
      n = 0;
      while (busy === 1'b1 && n < 2000) begin
         ack = (n == 8) ? 12'h018 : 12'h000;   // one-clock ack on lane 3 plus a masked-off lane
         n++;
         step();
      end
      n_chk++;
      if (n !== W + T + H) begin n_fail++; $display("FAIL to_busy_len: %0d want %0d", n, W + T + H); end
      n_chk++;
      if ({missing, to_cnt, trg_cnt} !== {12'h007, CW'(e_to), CW'(e_trg)}) begin
         n_fail++; $display("FAIL to_stats: miss=%h to=%0d trg_cnt=%0d want 007/%0d/%0d", missing, to_cnt, trg_cnt, e_to, e_trg);
      end
      trg_req = 1'b0; ack = '0;
      step();
   endtask

   task automatic test_busy_drop();
      trg_mask = 12'h003; ack = '0; trg_soft = 1'b1;
      step();
      e_trg = sat(e_trg);
      for (int i = 0; i < W; i++) step();
      for (int i = 0; i < 3; i++) begin trg_req = 1'b1; step(); trg_req = 1'b0; step(); e_lost = sat(e_lost); end
      n_chk++;
      if ({busy, lost_cnt} !== {1'b1, CW'(e_lost)}) begin n_fail++; $display("FAIL drop_lost: busy=%b lost=%0d want 1/%0d", busy, lost_cnt, e_lost); end
      ack = 12'h003;
      wait_idle("drop1", 100);
      trg_soft = 1'b0;
      step();
      trg_req = 1'b1; trg_soft = 1'b1;
      step();
      e_trg = sat(e_trg);
      n_chk++;
      if ({busy, trg, trg_cnt, lost_cnt} !== {1'b1, 12'h003, CW'(e_trg), CW'(e_lost)}) begin
         n_fail++; $display("FAIL drop_simul: busy=%b trg=%h trg_cnt=%0d lost=%0d want 1/003/%0d/%0d", busy, trg, trg_cnt, lost_cnt, e_trg, e_lost);
      end
      wait_idle("drop2", 100);
      trg_req = 1'b0; trg_soft = 1'b0;
      n_chk++;
      if ({to_cnt, missing} !== {CW'(e_to), 12'h000}) begin n_fail++; $display("FAIL drop_after: to=%0d miss=%h want %0d/000", to_cnt, missing, e_to); end
      step();
   endtask

   task automatic test_back_to_back();
      trg_mask = 12'h0A5; ack = 12'h0A5;
      step(); step();
      trg_soft = 1'b1;
      step();
      e_trg = sat(e_trg);
      trg_soft = 1'b0;
      for (int i = 2; i <= W + 1 + H; i++) step();
      n_chk++;
      if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_last_busy: busy=%b want 1", busy); end
      trg_req = 1'b1;   // lands on the last busy clock: dropped
      step();
      e_lost = sat(e_lost);
      n_chk++;
      if ({busy, lost_cnt} !== {1'b0, CW'(e_lost)}) begin n_fail++; $display("FAIL b2b_edge_drop: busy=%b lost=%0d want 0/%0d", busy, lost_cnt, e_lost); end
      trg_req = 1'b0; trg_soft = 1'b1;   // first idle clock: accepted
      step();
      e_trg = sat(e_trg);
      n_chk++;
      if ({busy, trg, trg_cnt} !== {1'b1, 12'h0A5, CW'(e_trg)}) begin
         n_fail++; $display("FAIL b2b_accept: busy=%b trg=%h trg_cnt=%0d want 1/0a5/%0d", busy, trg, trg_cnt, e_trg);
      end
      trg_soft = 1'b0;
      wait_idle("b2b", 100);
   endtask

   task automatic test_zero_mask();
      trg_mask = '0; ack = '0; trg_soft = 1'b1;
      for (int i = 0; i < 4; i++) begin
         step();
         n_chk++;
         if ({trg, busy} !== '0) begin n_fail++; $display("FAIL zmask_idle: trg=%h busy=%b want 0/0", trg, busy); end
      end
      e_lost = sat(e_lost);
      n_chk++;
      if ({lost_cnt, trg_cnt} !== {CW'(e_lost), CW'(e_trg)}) begin
         n_fail++; $display("FAIL zmask_cnt: lost=%0d trg_cnt=%0d want %0d/%0d", lost_cnt, trg_cnt, e_lost, e_trg);
      end
      trg_soft = 1'b0;
      step();
   endtask

   task automatic test_midop_reset();
      trg_mask = 12'hFFF; ack = '0; trg_soft = 1'b1;
      step(); step();
      n_chk++;
      if (trg !== 12'hFFF) begin n_fail++; $display("FAIL mid_fire2: trg=%h want fff", trg); end
      #1 rst_n = 1'b0;
      #1;
      n_chk++;
      if ({trg, busy, trg_cnt, lost_cnt, to_cnt, missing} !== '0) begin
         n_fail++; $display("FAIL mid_reset_async: trg=%h busy=%b cnt=%0d/%0d/%0d want all 0", trg, busy, trg_cnt, lost_cnt, to_cnt);
      end
      step();
      rst_n = 1'b1;
      step(); step();
      n_chk++;
      if ({busy, trg_cnt} !== '0) begin n_fail++; $display("FAIL mid_release: busy=%b trg_cnt=%0d want 0/0", busy, trg_cnt); end
      trg_soft = 1'b0;
      step();
      ack = 12'hFFF; trg_soft = 1'b1;
      step();
      n = 0;
      while (trg === 12'hFFF && n < 20) begin n++; step(); end
      n_chk++;
      if (n !== W) begin n_fail++; $display("FAIL mid_rerun_pulse: %0d clks want %0d", n, W); end
      trg_soft = 1'b0;
      wait_idle("mid", 100);
      e_trg = 1; e_lost = 0; e_to = 0;
   endtask

   task automatic test_saturation();
      ack = '0; trg_mask = 12'h001;
      for (int i = 0; i < CMAX + 1; i++) begin
         trg_soft = 1'b1; step(); trg_soft = 1'b0;
         e_trg = sat(e_trg); e_to = sat(e_to);
         wait_idle("sat_to", W + T + H + 10);
      end
      n_chk++;
      if ({trg_cnt, to_cnt, missing} !== {CW'(CMAX), CW'(CMAX), 12'h001}) begin
         n_fail++; $display("FAIL sat_trg_to: trg_cnt=%0d to=%0d miss=%h want %0d/%0d/001", trg_cnt, to_cnt, missing, CMAX, CMAX);
      end
      trg_mask = '0;
      for (int i = 0; i < CMAX + 2; i++) begin trg_soft = 1'b1; step(); trg_soft = 1'b0; step(); e_lost = sat(e_lost); end
      n_chk++;
      if (lost_cnt !== CW'(CMAX)) begin n_fail++; $display("FAIL sat_lost: lost=%0d want %0d", lost_cnt, CMAX); end
   endtask

   task automatic test_random();
      logic [N-1:0] r;
      rst_n = 1'b0; trg_req = 1'b0; trg_soft = 1'b0; ack = '0; trg_mask = '0;
      step(); step();
      m_first = 1'b1; m_busy = 0; m_fire = 0; m_trgc = 0; m_lost = 0; m_to = 0; m_maskl = '0; m_miss = '0;
      rst_n = 1'b1; mdl_on = 1'b1;
      for (int t = 0; t < 14; t++) begin
         trg_req = 1'b0; trg_soft = 1'b0;
         r = N'($urandom);
         trg_mask = ($urandom_range(0, 7) == 0) ? '0 : N'($urandom);
         ack = ($urandom_range(0, 3) != 0) ? (trg_mask | r) : (trg_mask & r);
         step(); step(); step();
         for (int c = 0; c < 60 || (m_busy != 0 && c < 1500); c++) begin
            if (c < 60) begin
               if ($urandom_range(0, 2) == 0) trg_req  = ~trg_req;
               if ($urandom_range(0, 3) == 0) trg_soft = ~trg_soft;
               if ($urandom_range(0, 9) == 0) trg_mask = N'($urandom);
            end else begin
               trg_req = 1'b0; trg_soft = 1'b0;
            end
            step();
            n_chk++;
            if (trg !== ((m_fire > 0) ? m_maskl : '0)) begin
               n_fail++; $display("FAIL rand_trg t%0d c%0d: trg=%h want %h", t, c, trg, (m_fire > 0) ? m_maskl : '0);
            end
            n_chk++;
            if ({busy, trg_cnt, lost_cnt} !== {(m_busy > 0), CW'(m_trgc), CW'(m_lost)}) begin
               n_fail++; $display("FAIL rand_state t%0d c%0d: busy=%b trg_cnt=%0d lost=%0d want %b/%0d/%0d",
                                  t, c, busy, trg_cnt, lost_cnt, m_busy > 0, m_trgc, m_lost);
            end
            if (m_busy == 0) begin
               n_chk++;
               if ({missing, to_cnt} !== {m_miss, CW'(m_to)}) begin
                  n_fail++; $display("FAIL rand_result t%0d c%0d: miss=%h to=%0d want %h/%0d", t, c, missing, to_cnt, m_miss, m_to);
               end
            end
         end
         n_chk++;
         if (m_busy != 0) begin n_fail++; $display("FAIL rand_drain t%0d: model still busy %0d", t, m_busy); end
      end
      mdl_on = 1'b0;
   endtask

   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_nominal();
      test_timeout();
      test_busy_drop();
      test_back_to_back();
      test_zero_mask();
      test_midop_reset();
      test_saturation();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
